// File: rtl/mem_loader_pkg.sv
// Shared types and constants for the boot-time program loader.
package mem_loader_pkg;

    localparam int BYTE_W = 8;
    localparam int WORD_W = 16;

    localparam logic [BYTE_W-1:0] SYNC_DEFAULT = 8'hA5;

    // Bytes between SYNC and the payload (ADDR_HI, ADDR_LO, CNT_HI, CNT_LO)
    localparam int HDR_BYTES  = 4;
    localparam int WORD_BYTES = 2;
    localparam int CSUM_BYTES = 1;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ADDR_HI = 3'd1,
        ST_ADDR_LO = 3'd2,
        ST_CNT_HI  = 3'd3,
        ST_CNT_LO  = 3'd4,
        ST_DATA_HI = 3'd5,
        ST_DATA_LO = 3'd6,
        ST_CSUM    = 3'd7
    } state_e;

endpackage

// File: rtl/mem_loader.sv
// Framed byte stream to 16-bit memory write port loader; holds the CPU via busy
// while a frame is in flight and reports done/err at frame end.
module mem_loader
    import mem_loader_pkg::*;
#(
    parameter int                DEPTH = 256,
    parameter logic [BYTE_W-1:0] SYNC  = SYNC_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [BYTE_W-1:0] in_data,
    output logic              in_ready,
    output logic              wen,
    output logic [WORD_W-1:0] waddr,
    output logic [WORD_W-1:0] wdata,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam logic [WORD_W:0] DEPTH_W = 17'(DEPTH);

    state_e            state_r;
    logic [WORD_W-1:0] addr_r;
    logic [WORD_W-1:0] cnt_r;
    logic [BYTE_W-1:0] xor_r;
    logic [BYTE_W-1:0] hi_r;
    logic              range_r;
    logic              in_ready_r;
    logic              wen_r;
    logic [WORD_W-1:0] waddr_r;
    logic [WORD_W-1:0] wdata_r;
    logic              busy_r;
    logic              done_r;
    logic              err_r;

    logic              xfer_s;
    logic              in_range_s;
    logic              last_word_s;

    // Byte handshake and per-word address/count decode
    always_comb begin
        xfer_s      = in_valid & in_ready_r;
        in_range_s  = ({1'b0, addr_r} < DEPTH_W);
        last_word_s = (cnt_r == 16'd1);
    end

    // Frame FSM with registered write port and status outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            addr_r     <= 16'd0;
            cnt_r      <= 16'd0;
            xor_r      <= 8'd0;
            hi_r       <= 8'd0;
            range_r    <= 1'b0;
            in_ready_r <= 1'b0;
            wen_r      <= 1'b0;
            waddr_r    <= 16'd0;
            wdata_r    <= 16'd0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            err_r      <= 1'b0;
        end else begin
            in_ready_r <= 1'b1;
            wen_r      <= 1'b0;
            done_r     <= 1'b0;
            if (xfer_s) begin
                case (state_r)
                    ST_IDLE: begin
                        if (in_data == SYNC) begin
                            err_r   <= 1'b0;
                            xor_r   <= 8'd0;
                            range_r <= 1'b0;
                            busy_r  <= 1'b1;
                            state_r <= ST_ADDR_HI;
                        end
                    end
                    ST_ADDR_HI: begin
                        addr_r[15:8] <= in_data;
                        xor_r        <= xor_r ^ in_data;
                        state_r      <= ST_ADDR_LO;
                    end
                    ST_ADDR_LO: begin
                        addr_r[7:0] <= in_data;
                        xor_r       <= xor_r ^ in_data;
                        state_r     <= ST_CNT_HI;
                    end
                    ST_CNT_HI: begin
                        cnt_r[15:8] <= in_data;
                        xor_r       <= xor_r ^ in_data;
                        state_r     <= ST_CNT_LO;
                    end
                    ST_CNT_LO: begin
                        cnt_r[7:0] <= in_data;
                        xor_r      <= xor_r ^ in_data;
                        state_r    <= ({cnt_r[15:8], in_data} == 16'd0) ? ST_CSUM : ST_DATA_HI;
                    end
                    ST_DATA_HI: begin
                        hi_r    <= in_data;
                        xor_r   <= xor_r ^ in_data;
                        state_r <= ST_DATA_LO;
                    end
                    ST_DATA_LO: begin
                        xor_r <= xor_r ^ in_data;
                        // Out-of-range words are dropped but the frame keeps going
                        if (in_range_s) begin
                            wen_r   <= 1'b1;
                            waddr_r <= addr_r;
                            wdata_r <= {hi_r, in_data};
                        end else begin
                            range_r <= 1'b1;
                        end
                        addr_r  <= addr_r + 16'd1;
                        cnt_r   <= cnt_r - 16'd1;
                        state_r <= last_word_s ? ST_CSUM : ST_DATA_HI;
                    end
                    ST_CSUM: begin
                        if ((in_data == xor_r) && !range_r) begin
                            done_r <= 1'b1;
                        end else begin
                            err_r <= 1'b1;
                        end
                        busy_r  <= 1'b0;
                        state_r <= ST_IDLE;
                    end
                    default: begin
                        state_r <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign in_ready = in_ready_r;
    assign wen      = wen_r;
    assign waddr    = waddr_r;
    assign wdata    = wdata_r;
    assign busy     = busy_r;
    assign done     = done_r;
    assign err      = err_r;

endmodule

// File: tb/tb_mem_loader.sv
// Scoreboard bench for mem_loader: stimulus pushes expected writes/frame ends,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_mem_loader;
    import mem_loader_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'd0;
    logic        in_ready;
    logic        wen;
    logic [15:0] waddr;
    logic [15:0] wdata;
    logic        busy;
    logic        done;
    logic        err;

    mem_loader #(.DEPTH(256), .SYNC(8'hA5)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .wen(wen), .waddr(waddr), .wdata(wdata),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // kind 0 = write (a, d), kind 1 = frame end (d[0] = expected err)
    typedef struct {
        int          kind;
        logic [15:0] a;
        logic [15:0] d;
        int          c;
    } ev_t;

    ev_t         exp_q[$];
    ev_t         mon_e;
    int          tests = 0;
    int          fails = 0;
    bit          gappy = 1'b0;
    logic [15:0] wbuf[0:7];
    logic        prev_busy = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Returns the cycle stamp at which the byte's registered effects are visible
    task automatic send_byte(input logic [7:0] b, output int tc);
        int tries = 0;
        if (gappy) repeat ($urandom_range(0, 2)) @(negedge clk);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready && tries < 20) begin
            @(negedge clk);
            tries++;
        end
        if (!in_ready) check("in_ready_timeout", 32'(in_ready), 32'd1);
        tc = cyc + 1;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [15:0] addr, input logic [15:0] cnt,
                              input logic [7:0] csum, input bit exp_err);
        int          tc;
        logic [15:0] a;
        ev_t         e;
        send_byte(8'hA5, tc);
        @(negedge clk);
        check("busy_after_sync", 32'(busy), 32'd1);
        check("err_cleared_by_sync", 32'(err), 32'd0);
        send_byte(addr[15:8], tc);
        send_byte(addr[7:0], tc);
        send_byte(cnt[15:8], tc);
        send_byte(cnt[7:0], tc);
        a = addr;
        for (int i = 0; i < int'(cnt); i++) begin
            send_byte(wbuf[i][15:8], tc);
            send_byte(wbuf[i][7:0], tc);
            if (a < 16'd256) begin
                e.kind = 0; e.a = a; e.d = wbuf[i]; e.c = tc;
                exp_q.push_back(e);
            end
            a = a + 16'd1;
        end
        send_byte(csum, tc);
        e.kind = 1; e.a = 16'd0; e.d = {15'd0, exp_err}; e.c = tc;
        exp_q.push_back(e);
    endtask

    // Monitor: every write and every busy fall must match the scoreboard head
    always @(negedge clk) begin
        if (reset) begin
            prev_busy <= 1'b0;
        end else begin
            prev_busy <= busy;
            if (wen) begin
                check("wen_expected", 32'(exp_q.size() > 0 && exp_q[0].kind == 0), 32'd1);
                if (exp_q.size() > 0 && exp_q[0].kind == 0) begin
                    mon_e = exp_q.pop_front();
                    check("waddr", 32'(waddr), 32'(mon_e.a));
                    check("wdata", 32'(wdata), 32'(mon_e.d));
                    check("wen_cycle", 32'(cyc), 32'(mon_e.c));
                end
            end
            if (prev_busy && !busy) begin
                check("end_expected", 32'(exp_q.size() > 0 && exp_q[0].kind == 1), 32'd1);
                if (exp_q.size() > 0 && exp_q[0].kind == 1) begin
                    mon_e = exp_q.pop_front();
                    check("done_at_end", 32'(done), 32'(!mon_e.d[0]));
                    check("err_at_end", 32'(err), 32'(mon_e.d[0]));
                    check("end_cycle", 32'(cyc), 32'(mon_e.c));
                end
            end else if (done) begin
                check("stray_done", 32'(done), 32'd0);
            end
        end
    end

    initial begin
        int tc;
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int tc;
        repeat (3) @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_wen", 32'(wen), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_waddr", 32'(waddr), 32'd0);
        check("rst_wdata", 32'(wdata), 32'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Basic two-word frame
        wbuf[0] = 16'h1234; wbuf[1] = 16'hABCD;
        send_frame(16'h0010, 16'd2, 8'h52, 1'b0);

        // Bad checksum: writes still land, err sticky until next SYNC
        send_frame(16'h0010, 16'd2, 8'h53, 1'b1);
        repeat (4) @(negedge clk);
        check("err_sticky", 32'(err), 32'd1);
        check("no_done_after_err", 32'(done), 32'd0);

        // Zero-count frame
        send_frame(16'h0000, 16'd0, 8'h00, 1'b0);

        // Range: 0x00FF written, 0x0100 suppressed
        wbuf[0] = 16'h1111; wbuf[1] = 16'h2222;
        send_frame(16'h00FF, 16'd2, 8'hFD, 1'b1);

        // Address wrap: 0xFFFF suppressed, 0x0000 written
        wbuf[0] = 16'hBEEF; wbuf[1] = 16'hCAFE;
        send_frame(16'hFFFF, 16'd2, 8'h67, 1'b1);

        // Garbage before SYNC, then gappy valid
        send_byte(8'h00, tc);
        send_byte(8'hFF, tc);
        send_byte(8'h5A, tc);
        @(negedge clk);
        check("garbage_no_busy", 32'(busy), 32'd0);
        gappy = 1'b1;
        wbuf[0] = 16'h1234; wbuf[1] = 16'hABCD;
        send_frame(16'h0010, 16'd2, 8'h52, 1'b0);
        gappy = 1'b0;

        // Reset coincident with the DATA_LO transfer cancels the write
        send_byte(8'hA5, tc);
        send_byte(8'h00, tc);
        send_byte(8'h10, tc);
        send_byte(8'h00, tc);
        send_byte(8'h02, tc);
        send_byte(8'h12, tc);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 8'h34;
        reset    = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        check("mid_rst_wen", 32'(wen), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_err", 32'(err), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        check("mid_rst_in_ready", 32'(in_ready), 32'd0);
        check("mid_rst_waddr", 32'(waddr), 32'd0);
        check("mid_rst_wdata", 32'(wdata), 32'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        send_frame(16'h0010, 16'd2, 8'h52, 1'b0);

        repeat (5) @(negedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
